// File: rtl/led_fade_pkg.sv
// Shared constants and types for the LED fade/PWM driver.
// Default widths and dividers used as parameter defaults by the driver.
package led_fade_pkg;

    localparam int DEF_NUM_LEDS  = 10;
    localparam int DEF_PWM_BITS  = 8;
    localparam int DEF_PRESCALE  = 50;
    localparam int DEF_FADE_DIV  = 4;
    localparam int DEF_BLINK_DIV = 64;

    typedef logic [DEF_PWM_BITS-1:0] duty_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: duty ramp register, PWM compare and output flop.
// The blank input forces the registered output low (used for blinking).
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] target,
    input  logic                fade_tick,
    input  logic                fade_bypass,
    input  logic                blank,
    output logic                led_out,
    output logic                differs
);

    localparam logic [PWM_BITS-1:0] FULL = '1;

    logic [PWM_BITS-1:0] duty;
    logic                pwm_on;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty <= '0;
        end else if (fade_bypass) begin
            duty <= target;
        end else if (fade_tick) begin
            if (duty < target) begin
                duty <= duty + 1'b1;
            end else if (duty > target) begin
                duty <= duty - 1'b1;
            end
        end
    end

    // All-ones duty means fully on; a plain compare would drop one count.
    assign pwm_on  = (duty == FULL) || (pwm_cnt < duty);
    assign differs = (duty != target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= 1'b0;
        end else begin
            led_out <= pwm_on && !blank;
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: shared prescaler/PWM/fade counters plus per-LED channels.
// Optional blinking is enabled by defining LED_FADE_BLINK_EN.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int FADE_DIV  = DEF_FADE_DIV,
    parameter int BLINK_DIV = DEF_BLINK_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                fade_bypass,
    input  logic [NUM_LEDS-1:0] blink_mask,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FADE_W-1:0]   fade_cnt;
    logic                pwm_tick;
    logic                period_end;
    logic                fade_tick;
    logic [NUM_LEDS-1:0] blank;
    logic [NUM_LEDS-1:0] differs;

    assign pwm_tick   = (pre_cnt == PRE_LAST);
    assign period_end = pwm_tick && (pwm_cnt == '1);
    assign fade_tick  = period_end && (fade_cnt == FADE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else begin
            pre_cnt <= pwm_tick ? '0 : pre_cnt + 1'b1;
            if (pwm_tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (period_end) begin
                fade_cnt <= (fade_cnt == FADE_LAST) ? '0 : fade_cnt + 1'b1;
            end
        end
    end

`ifdef LED_FADE_BLINK_EN
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0] blink_cnt;
    logic             blink_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (period_end) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= !blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blank = blink_mask & {NUM_LEDS{!blink_phase}};
`else
    logic unused_blink;

    assign blank        = '0;
    assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        logic [PWM_BITS-1:0] target;

        assign target = led_in[i] ? brightness : '0;

        led_fade_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .pwm_cnt    (pwm_cnt),
            .target     (target),
            .fade_tick  (fade_tick),
            .fade_bypass(fade_bypass),
            .blank      (blank[i]),
            .led_out    (led_out[i]),
            .differs    (differs[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |differs;
        end
    end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with a 16-clk PWM period.
// Each vector runs one period and checks per-LED high counts and busy.
module tb_led_fade_driver;

    localparam int N = 10;
    localparam int W = 4;
`ifdef LED_FADE_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] led_in = '0;
    logic [W-1:0] brightness = '0;
    logic         fade_bypass = 1'b0;
    logic [N-1:0] blink_mask = '0;
    logic [N-1:0] led_out;
    logic         busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_fade_driver #(
        .NUM_LEDS (N),
        .PWM_BITS (W),
        .PRESCALE (1),
        .FADE_DIV (1),
        .BLINK_DIV(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .led_in     (led_in),
        .brightness (brightness),
        .fade_bypass(fade_bypass),
        .blink_mask (blink_mask),
        .led_out    (led_out),
        .busy       (busy)
    );

    typedef struct {
        bit           rst;
        logic [N-1:0] li;
        logic [W-1:0] br;
        bit           byp;
        logic [N-1:0] mask;
        int           c0;
        int           c1;
        int           c9;
        bit           cb;
        bit           bf;
        bit           bl;
    } vec_t;

    vec_t q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input logic [N-1:0] li,
                       input logic [W-1:0] br, input bit byp,
                       input logic [N-1:0] mask, input int c0,
                       input int c1, input int c9, input bit cb,
                       input bit bf, input bit bl);
        vec_t v;
        v.rst = rst; v.li = li; v.br = br; v.byp = byp; v.mask = mask;
        v.c0 = c0; v.c1 = c1; v.c9 = c9;
        v.cb = cb; v.bf = bf; v.bl = bl;
        q.push_back(v);
    endtask

    // Called at a negedge with pwm_cnt at 0; returns at a negedge.
    task automatic run_vec(input vec_t v, input int idx);
        int  c0, c1, c9;
        bit  bf, bl;
        c0 = 0; c1 = 0; c9 = 0; bf = 0; bl = 0;
        led_in      = v.li;
        brightness  = v.br;
        fade_bypass = v.byp;
        blink_mask  = v.mask;
        if (v.rst) begin
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end
        for (int t = 0; t < 16; t++) begin
            @(posedge clk);
            @(negedge clk);
            if (led_out[0]) c0++;
            if (led_out[1]) c1++;
            if (led_out[9]) c9++;
            if (t == 0)  bf = busy;
            if (t == 15) bl = busy;
        end
        check($sformatf("v%0d led0_on", idx), c0, v.c0);
        check($sformatf("v%0d led1_on", idx), c1, v.c1);
        check($sformatf("v%0d led9_on", idx), c9, v.c9);
        if (v.cb) begin
            check($sformatf("v%0d busy_first", idx), int'(bf), int'(v.bf));
            check($sformatf("v%0d busy_last", idx), int'(bl), int'(v.bl));
        end
    endtask

    initial begin
        int n_a;

        // Ramp 0 -> 15 on LED0, then hold fully on.
        for (int k = 1; k <= 16; k++) begin
            add(k == 1, 10'h001, 4'd15, 1'b0, '0,
                (k == 16) ? 16 : k - 1, 0, 0, 1'b1, k < 16, k < 16);
        end
        add(0, 10'h001, 4'd15, 0, '0, 16, 0, 0, 1, 0, 0);
        add(0, 10'h001, 4'd15, 0, '0, 16, 0, 0, 1, 0, 0);
        // Bypass to 8 on all LEDs.
        add(0, 10'h3FF, 4'd8, 1, '0, 8, 7, 7, 0, 0, 0);
        add(0, 10'h3FF, 4'd8, 1, '0, 8, 8, 8, 1, 0, 0);
        // Start ramping 8 -> 15; reset is pulsed after this period.
        add(0, 10'h3FF, 4'd15, 0, '0, 8, 8, 8, 1, 1, 1);
        n_a = q.size();
        // Ramp restarts from 0 after the mid-ramp reset.
        add(0, 10'h3FF, 4'd15, 0, '0, 0, 0, 0, 1, 1, 1);
        add(0, 10'h3FF, 4'd15, 0, '0, 1, 1, 1, 1, 1, 1);
        // Ramp toward 12, retarget to 4 at duty 6, then drop led_in.
        for (int k = 1; k <= 6; k++) begin
            add(k == 1, 10'h001, 4'd12, 1'b0, '0, k - 1, 0, 0, 1'b1, 1'b1, 1'b1);
        end
        add(0, 10'h001, 4'd4, 0, '0, 6, 0, 0, 1, 1, 1);
        add(0, 10'h001, 4'd4, 0, '0, 5, 0, 0, 1, 1, 1);
        add(0, 10'h001, 4'd4, 0, '0, 4, 0, 0, 1, 0, 0);
        add(0, 10'h001, 4'd4, 0, '0, 4, 0, 0, 1, 0, 0);
        add(0, 10'h000, 4'd4, 0, '0, 4, 0, 0, 1, 1, 1);
        add(0, 10'h000, 4'd4, 0, '0, 3, 0, 0, 1, 1, 1);
        // Blink on LED1, full duty via bypass.
        add(1, 10'h003, 4'd15, 1, 10'h002, 15, 15, 0, 0, 0, 0);
        add(0, 10'h003, 4'd15, 1, 10'h002, 16, 16, 0, 1, 0, 0);
        add(0, 10'h003, 4'd15, 1, 10'h002, 16, BLINK ? 0 : 16, 0, 1, 0, 0);
        add(0, 10'h003, 4'd15, 1, 10'h002, 16, BLINK ? 0 : 16, 0, 1, 0, 0);
        add(0, 10'h003, 4'd15, 1, 10'h002, 16, 16, 0, 1, 0, 0);
        add(0, 10'h003, 4'd15, 1, 10'h002, 16, 16, 0, 1, 0, 0);
        add(0, 10'h003, 4'd15, 1, 10'h002, 16, BLINK ? 0 : 16, 0, 1, 0, 0);

        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("reset led_out", int'(led_out), 0);
        check("reset busy", int'(busy), 0);

        for (int i = 0; i < n_a; i++) begin
            run_vec(q[i], i);
        end

        // Duty is 9 on all LEDs here; pulse reset asynchronously mid-cycle.
        @(posedge clk);
        #2;
        check("pre-reset led_out", int'(led_out), 10'h3FF);
        check("pre-reset busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("async reset led_out", int'(led_out), 0);
        check("async reset busy", int'(busy), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = n_a; i < q.size(); i++) begin
            run_vec(q[i], i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
